// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, round constants, key-schedule FSM
// encoding and a byte-lane helper used by the key-schedule datapaths.
package aes_pkg;

    localparam int AES_ROUNDS = 10;

    // Round constants indexed directly by round number. Entry 0 and entries
    // 11..15 are never used by AES-128; they are zero so a 4-bit index is
    // always in range.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT   = 2'd1,
        FINISH = 2'd2
    } ks_state_e;

    // Byte n of a 32-bit word; byte 0 lives in bits [7:0].
    function automatic logic [7:0] getByte(input logic [31:0] word, input logic [1:0] n);
        return word[{n, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sbox_lookup.sv
// Combinational AES forward S-box, one byte in, one byte out.
module sbox_lookup (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign sub_val = SBOX[byte_val];

endmodule

// File: rtl/inv_key_schedule.sv
// Iterative AES-128 inverse key schedule. Starting from the round-10 key it
// walks the expansion backwards, presenting round keys 10 down to 0 on a
// valid/ready interface, one key per handshake.
module inv_key_schedule
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_WIDTH  = 128
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [KEY_WIDTH-1:0] lastKey,
    input  logic                 keyReady,
    output logic [KEY_WIDTH-1:0] roundKey,
    output logic [3:0]           roundNum,
    output logic                 keyValid,
    output logic                 busy,
    output logic                 done
);

    // Only AES-128 is implemented; any other configuration stops elaboration.
    if (NUM_ROUNDS != AES_ROUNDS || KEY_WIDTH != 128) begin : g_bad_config
        $error("inv_key_schedule supports only NUM_ROUNDS=10 and KEY_WIDTH=128");
    end

    ks_state_e state;
    ks_state_e state_next;

    logic        handshake;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [KEY_WIDTH-1:0] prev_key;

    assign handshake = keyValid && keyReady;

    // Undo one forward expansion step: words 1..3 come from pairwise XORs,
    // word 0 needs SubWord(RotWord()) of the recovered word 3 plus Rcon.
    assign w0 = roundKey[31:0];
    assign w1 = roundKey[63:32];
    assign w2 = roundKey[95:64];
    assign w3 = roundKey[127:96];

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    // RotWord moves byte 1 into byte 0, byte 2 into byte 1, and so on.
    assign rot_word = {getByte(p3, 2'd0), getByte(p3, 2'd3), getByte(p3, 2'd2), getByte(p3, 2'd1)};

    for (genvar n = 0; n < 4; n++) begin : g_subword
        sbox_lookup u_sbox (
            .byte_val (rot_word[8*n +: 8]),
            .sub_val  (sub_word[8*n +: 8])
        );
    end

    assign p0       = w0 ^ sub_word ^ {24'h0, RCON[roundNum]};
    assign prev_key = {p3, p2, p1, p0};

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    // NOTE: state_next is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = EMIT;
            EMIT:    if (keyReady && roundNum == 4'd0) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        keyValid = (state == EMIT);
        busy     = (state == EMIT);
        done     = (state == FINISH);
    end

    // Round-key datapath: load on start, step back one round per handshake,
    // hold otherwise so the last key stays visible after the run.
    always_ff @(posedge clock) begin
        if (reset) begin
            roundKey <= '0;
            roundNum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        roundKey <= lastKey;
                        roundNum <= 4'(NUM_ROUNDS);
                    end
                end
                EMIT: begin
                    if (handshake && roundNum != 4'd0) begin
                        roundKey <= prev_key;
                        roundNum <= roundNum - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Self-checking bench for inv_key_schedule. The reference runs the ordinary
// forward AES-128 key expansion from a cipher key, with its S-box derived
// from GF(2^8) inversion plus the affine map, and expects the DUT to emit
// that expansion in reverse.
module tb_inv_key_schedule;

    localparam logic [127:0] FIPS_CK = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] FIPS_LK = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
    localparam logic [127:0] ZERO_LK = 128'h8e188f6fcf51e92311e2923ecb5befb4;

    logic         clock;
    logic         reset;
    logic         start;
    logic [127:0] lastKey;
    logic         keyReady;
    logic [127:0] roundKey;
    logic [3:0]   roundNum;
    logic         keyValid;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox_ref [256];
    logic [127:0] rk  [0:10];
    logic [127:0] got [0:10];

    inv_key_schedule dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .lastKey  (lastKey),
        .keyReady (keyReady),
        .roundKey (roundKey),
        .roundNum (roundNum),
        .keyValid (keyValid),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc = 8'h00;
        logic [7:0] x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc ^= x;
            x = xtime(x);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Build the S-box from its mathematical definition.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward AES-128 key expansion into rk[0..10].
    task automatic expand(input logic [127:0] ck);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = ck[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[7:0], t[31:8]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
                t ^= {24'h0, rc};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endtask

    // One complete run, entered and left at a falling edge with the DUT idle.
    // stall_at/poke_at/abort_at select the round at which back-pressure, a
    // stray start, or a reset is applied (-1 disables).
    task automatic run_keys(input string tag, input logic [127:0] ck, input logic [127:0] lk,
                            input bit rand_ready, input int stall_at, input int stall_len,
                            input int poke_at, input int abort_at);
        int  exp_round = 10;
        int  stalled   = 0;
        int  cycles    = 0;
        bit  finished  = 0;
        expand(ck);
        start   = 1'b1;
        lastKey = lk;
        @(negedge clock);
        start   = 1'b0;
        lastKey = {$urandom, $urandom, $urandom, $urandom};
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            cycles++;
            check($sformatf("%s_valid_r%0d", tag, exp_round), 128'(keyValid), 128'd1);
            check($sformatf("%s_busy_r%0d", tag, exp_round), 128'(busy), 128'd1);
            check($sformatf("%s_done_r%0d", tag, exp_round), 128'(done), 128'd0);
            check($sformatf("%s_num_r%0d", tag, exp_round), 128'(roundNum), 128'(exp_round));
            check($sformatf("%s_key_r%0d", tag, exp_round), roundKey, rk[exp_round]);
            got[exp_round] = roundKey;
            if (exp_round == abort_at) begin
                reset    = 1'b1;
                keyReady = 1'b1;
                @(negedge clock);
                check({tag, "_rst_key"}, roundKey, 128'd0);
                check({tag, "_rst_num"}, 128'(roundNum), 128'd0);
                check({tag, "_rst_valid"}, 128'(keyValid), 128'd0);
                check({tag, "_rst_busy"}, 128'(busy), 128'd0);
                check({tag, "_rst_done"}, 128'(done), 128'd0);
                reset = 1'b0;
                @(negedge clock);
                check({tag, "_post_rst_valid"}, 128'(keyValid), 128'd0);
                check({tag, "_post_rst_busy"}, 128'(busy), 128'd0);
                return;
            end
            if (exp_round == poke_at && cycles == 11 - poke_at) begin
                start   = 1'b1;
                lastKey = ~lk;
            end
            if (exp_round == stall_at && stalled < stall_len) begin
                keyReady = 1'b0;
                stalled++;
            end else if (rand_ready) begin
                keyReady = 1'($urandom_range(0, 1));
            end else begin
                keyReady = 1'b1;
            end
            @(negedge clock);
            start = 1'b0;
            if (keyReady) begin
                if (exp_round == 0) finished = 1;
                else exp_round--;
            end
        end
        if (!finished) begin
            check({tag, "_timeout"}, 128'd0, 128'd1);
            return;
        end
        if (!rand_ready) check({tag, "_valid_cycles"}, 128'(cycles), 128'(11 + stall_len));
        check({tag, "_end_done"}, 128'(done), 128'd1);
        check({tag, "_end_valid"}, 128'(keyValid), 128'd0);
        check({tag, "_end_busy"}, 128'(busy), 128'd0);
        check({tag, "_end_num"}, 128'(roundNum), 128'd0);
        check({tag, "_end_key"}, roundKey, rk[0]);
        @(negedge clock);
        check({tag, "_idle_done"}, 128'(done), 128'd0);
        check({tag, "_idle_key"}, roundKey, rk[0]);
    endtask

    initial begin
        logic [127:0] ck;
        reset    = 1'b1;
        start    = 1'b0;
        keyReady = 1'b0;
        lastKey  = '0;
        build_sbox();
        @(negedge clock);
        @(negedge clock);
        check("reset_key", roundKey, 128'd0);
        check("reset_num", 128'(roundNum), 128'd0);
        check("reset_valid", 128'(keyValid), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        reset = 1'b0;
        @(negedge clock);

        // Known-answer run with free-flowing ready.
        run_keys("fips", FIPS_CK, FIPS_LK, 0, -1, 0, -1, -1);
        check("fips_kat_r10", got[10], FIPS_LK);
        check("fips_kat_r9", got[9], 128'h6e005c574129d12821dcfa19f36677ac);
        check("fips_kat_r1", got[1], 128'h05766c2a3939a323b12c548817fefaa0);
        check("fips_kat_r0", got[0], 128'h3c4fcf098815f7aba6d2ae2816157e2b);

        // Back-to-back: started in the cycle right after done.
        run_keys("zero", 128'd0, ZERO_LK, 0, -1, 0, -1, -1);
        check("zero_kat_r0", got[0], 128'd0);

        // Ready low for three cycles while round 7 is presented.
        run_keys("bp", FIPS_CK, FIPS_LK, 0, 7, 3, -1, -1);

        // Stray start with a different key during round 5.
        run_keys("poke", FIPS_CK, FIPS_LK, 0, -1, 0, 5, -1);

        // Reset at round 4, then a clean restart.
        run_keys("abort", FIPS_CK, FIPS_LK, 0, -1, 0, -1, 4);
        run_keys("restart", FIPS_CK, FIPS_LK, 0, -1, 0, -1, -1);
        check("restart_kat_r0", got[0], 128'h3c4fcf098815f7aba6d2ae2816157e2b);

        // Random cipher keys with random back-pressure and idle gaps.
        for (int t = 0; t < 8; t++) begin
            ck = {$urandom, $urandom, $urandom, $urandom};
            expand(ck);
            run_keys($sformatf("rnd%0d", t), ck, rk[10], 1, -1, 0, -1, -1);
            keyReady = 1'b0;
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_key_schedule.md
Name: inv_key_schedule

Overview:
- Iterative AES-128 inverse key schedule for the decryption datapath.
- Accepts the final (round 10) round key and walks the expansion backwards, producing round keys 10, 9, …, 0, one per valid/ready handshake.
- Feeds the decrypt-side add_round_key stage, so no 176-byte forward-expanded key store is needed.
- Byte order follows the codebase: AES byte 0 is in bits [7:0] and word w0 is bits [31:0].

Parameters:
- NUM_ROUNDS, 10: number of rounds. Only 10 (AES-128) is supported; any other value is a synthesis error.
- KEY_WIDTH, 128: round-key width. Fixed at 128.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a schedule run; sampled only in IDLE.
- lastKey  input  128  round-10 key, captured on an accepted start.
- keyReady  input  1  downstream can take roundKey this cycle.
- roundKey  output  128  current round key.
- roundNum  output  4  index of roundKey, 10 down to 0.
- keyValid  output  1  roundKey/roundNum are valid.
- busy  output  1  high from accepted start until the round-0 handshake completes.
- done  output  1  one-cycle pulse after the round-0 handshake.

Behaviour:
- Reset values: roundKey = 0, roundNum = 0, keyValid = 0, busy = 0, done = 0, FSM = IDLE. Reset mid-run aborts at once; no further keys are emitted.
- FSM states: IDLE, EMIT, FINISH.
- IDLE:
  - On start = 1: load roundKey <= lastKey, roundNum <= 10, keyValid <= 1, busy <= 1, go to EMIT.
  - Latency: start seen in cycle N gives the round-10 key valid in cycle N+1.
- EMIT:
  - While keyValid && !keyReady, roundKey and roundNum hold stable.
  - On a handshake with roundNum > 0: next cycle roundKey <= prev(roundKey, roundNum), roundNum decrements, keyValid stays 1.
  - With keyReady held high, one key is emitted per cycle, 11 cycles total.
  - On a handshake with roundNum == 0: keyValid <= 0, busy <= 0, done <= 1, go to FINISH.
- FINISH: done lasts one cycle, then IDLE; roundKey and roundNum keep their last values.
- start outside IDLE is ignored. A new start is accepted in the cycle after FINISH.
- prev(K, i), with K words w0..w3 and results p0..p3:
  - p3 = w3 ^ w2
  - p2 = w2 ^ w1
  - p1 = w1 ^ w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {24'h0, Rcon[i]}
- RotWord/Rcon conventions (codebase byte order):
  - RotWord: byte order (b0, b1, b2, b3) becomes (b1, b2, b3, b0).
  - Rcon sits in byte 0 of the word.
  - Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- prev() is one combinational cycle: 4 S-box lookups plus XORs, registered into roundKey.

Decomposition:
- Shared package aes_pkg holds:
  - the RCON constant table,
  - AES_ROUNDS = 10,
  - the state encodings IDLE/EMIT/FINISH,
  - a byte-lane helper, getByte(word, n).
- Sub-module sbox_lookup: combinational 8-bit forward S-box, 4 instances for SubWord. It is shared with the encrypt-side sub_bytes and key expansion.

Test Plan:
- FIPS-197 run:
  - Stimulus: lastKey = 128'ha60c63b6c80c3fe18925eec9a8f914d0, keyReady held 1.
  - Required: round 10 equals the input; round 9 = 128'h6e005c574129d12821dcfa19f36677ac; round 1 = 128'h05766c2a3939a323b12c548817fefaa0; round 0 = 128'h3c4fcf098815f7aba6d2ae2816157e2b.
  - Required: 11 consecutive valid cycles, and done in the cycle after round 0.
- All-zero cipher key:
  - Stimulus: lastKey = 128'h8e188f6fcf51e92311e2923ecb5befb4.
  - Required: round 0 = 128'h0 and roundNum = 0 on the final handshake.
- Backpressure:
  - Stimulus: keyReady low for 3 cycles while round 7 is presented.
  - Required: roundKey and roundNum stay constant throughout; round 6 appears one cycle after keyReady rises; values match the FIPS run.
- Start while busy:
  - Stimulus: pulse start with a different lastKey during round 5.
  - Required: the sequence is unaffected, and busy/done timing is unchanged.
- Reset mid-run:
  - Stimulus: assert reset at round 4 for one cycle, then start with the FIPS key.
  - Required: all outputs are 0 in the cycle after reset, and the restarted run is correct from round 10.
- Back-to-back runs:
  - Stimulus: start in the cycle after done, using the zero-key vector.
  - Required: the round-10 key is valid one cycle later, and the second sequence is correct.
